// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared state encoding and widths for the 8:1 mux scan controller
package mux_scan_pkg;
   typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
   localparam int NUM_CH = 8;
   localparam int SEL_W  = 3;
   localparam int CNT_W  = 4;
endpackage

// File: rtl/mux8_scan_ctrl_settle_timer.sv
// settle_timer: counts enabled clocks and pulses done when the count reaches SETTLE_CYCLES
module settle_timer import mux_scan_pkg::*; #(
   parameter int SETTLE_CYCLES = 1
)(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic done
);
   logic [CNT_W-1:0] r_cnt;
   assign done = en && (r_cnt == CNT_W'(SETTLE_CYCLES));
   always_ff @(posedge clk)
      r_cnt <= (rst || clr || done) ? '0 : en ? r_cnt + CNT_W'(1) : r_cnt;
endmodule

// File: rtl/mux8_scan_ctrl.sv
// mux8_scan_ctrl: steps an 8:1 mux through all channels, assembles a byte, hands it off valid/ready
// Define MUX_SCAN_PARITY_EN to add the registered even-parity output word_par.
module mux8_scan_ctrl import mux_scan_pkg::*; #(
   parameter int SETTLE_CYCLES = 1,
   parameter int CONTINUOUS    = 0
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mux_out,
   output logic [SEL_W-1:0] sel,
   output logic             busy,
   output logic [7:0]       word_data,
   output logic             word_valid,
   input  logic             word_ready
`ifdef MUX_SCAN_PARITY_EN
   ,
   output logic             word_par
`endif
);
   state_t           r_state, w_state_nx;
   logic [SEL_W-1:0] r_sel, w_sel_nx;
   logic [7:0]       r_word, w_word_nx, w_word_smp;
   logic             r_valid, w_valid_nx;
   logic             w_clr, w_done, w_last;

   settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (w_clr),
      .en   (r_state == SCAN),
      .done (w_done)
   );

   assign w_last = r_sel == SEL_W'(NUM_CH - 1);

   always_comb begin
      w_state_nx         = r_state;
      w_sel_nx           = r_sel;
      w_word_nx          = r_word;
      w_valid_nx         = r_valid;
      w_clr              = 1'b0;
      w_word_smp         = r_word;
      w_word_smp[r_sel]  = mux_out;
      case (r_state)
         IDLE: if (start) begin
            w_state_nx = SCAN;
            w_sel_nx   = '0;
            w_clr      = 1'b1;
         end
         SCAN: if (w_done) begin
            w_word_nx  = w_word_smp;
            w_sel_nx   = w_last ? '0 : r_sel + SEL_W'(1);
            w_state_nx = w_last ? HOLD : SCAN;
            w_valid_nx = w_last;
         end
         HOLD: if (word_ready) begin
            w_valid_nx = 1'b0;
            w_state_nx = (CONTINUOUS != 0) ? SCAN : IDLE;
            w_clr      = 1'b1;
         end
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_sel   <= '0;
         r_word  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_sel   <= w_sel_nx;
         r_word  <= w_word_nx;
         r_valid <= w_valid_nx;
      end
   end

`ifdef MUX_SCAN_PARITY_EN
   logic r_par;
   always_ff @(posedge clk)
      r_par <= rst ? 1'b0 : (r_state == SCAN && w_done && w_last) ? ^w_word_smp : r_par;
   assign word_par = r_par;
`endif

   assign sel        = r_sel;
   assign busy       = r_state != IDLE;
   assign word_data  = r_word;
   assign word_valid = r_valid;
endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// tb_mux8_scan_ctrl: directed checks of three configurations (S=1 one-shot, S=1 continuous, S=0 one-shot)
module tb_mux8_scan_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       st  [3];
   logic       rd  [3];
   logic [7:0] pat [3];
   logic       mo  [3];
   logic [2:0] sel_o [3];
   logic       busy_o [3];
   logic [7:0] data_o [3];
   logic       vld_o [3];
`ifdef MUX_SCAN_PARITY_EN
   logic       par_o [3];
`endif
   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   assign mo[0] = pat[0][sel_o[0]];
   assign mo[1] = pat[1][sel_o[1]];
   assign mo[2] = pat[2][sel_o[2]];

   mux8_scan_ctrl #(.SETTLE_CYCLES(1), .CONTINUOUS(0)) u0 (
      .clk(clk), .rst(rst), .start(st[0]), .mux_out(mo[0]), .sel(sel_o[0]), .busy(busy_o[0]),
      .word_data(data_o[0]), .word_valid(vld_o[0]), .word_ready(rd[0])
`ifdef MUX_SCAN_PARITY_EN
      , .word_par(par_o[0])
`endif
   );
   mux8_scan_ctrl #(.SETTLE_CYCLES(1), .CONTINUOUS(1)) u1 (
      .clk(clk), .rst(rst), .start(st[1]), .mux_out(mo[1]), .sel(sel_o[1]), .busy(busy_o[1]),
      .word_data(data_o[1]), .word_valid(vld_o[1]), .word_ready(rd[1])
`ifdef MUX_SCAN_PARITY_EN
      , .word_par(par_o[1])
`endif
   );
   mux8_scan_ctrl #(.SETTLE_CYCLES(0), .CONTINUOUS(0)) u2 (
      .clk(clk), .rst(rst), .start(st[2]), .mux_out(mo[2]), .sel(sel_o[2]), .busy(busy_o[2]),
      .word_data(data_o[2]), .word_valid(vld_o[2]), .word_ready(rd[2])
`ifdef MUX_SCAN_PARITY_EN
      , .word_par(par_o[2])
`endif
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_idle(input int u);
      check($sformatf("u%0d idle sel", u), 8'(sel_o[u]), 8'd0);
      check($sformatf("u%0d idle busy", u), 8'(busy_o[u]), 8'd0);
      check($sformatf("u%0d idle valid", u), 8'(vld_o[u]), 8'd0);
   endtask

   // one full scan of unit u; start pulse optional, extra start pulse at step xs (0 = none)
   task automatic scan(input int u, input int s, input logic [7:0] p, input bit do_start, input int xs);
      int n = 8 * (s + 1);
      pat[u] = p;
      if (do_start) begin
         st[u] = 1'b1;
         @(negedge clk);
         st[u] = 1'b0;
         check($sformatf("u%0d start busy", u), 8'(busy_o[u]), 8'd1);
         check($sformatf("u%0d start sel", u), 8'(sel_o[u]), 8'd0);
      end
      for (int m = 1; m <= n; m++) begin
         st[u] = (m == xs);
         @(negedge clk);
         check($sformatf("u%0d sel m=%0d", u, m), 8'(sel_o[u]), (m == n) ? 8'd0 : 8'(m / (s + 1)));
         check($sformatf("u%0d valid m=%0d", u, m), 8'(vld_o[u]), 8'(m == n));
      end
      st[u] = 1'b0;
      check($sformatf("u%0d data", u), data_o[u], p);
      check($sformatf("u%0d busy hold", u), 8'(busy_o[u]), 8'd1);
`ifdef MUX_SCAN_PARITY_EN
      check($sformatf("u%0d par", u), 8'(par_o[u]), 8'(^p));
`endif
   endtask

   task automatic accept(input int u, input int hold, input logic [7:0] p);
      rd[u] = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check($sformatf("u%0d bp valid %0d", u, i), 8'(vld_o[u]), 8'd1);
         check($sformatf("u%0d bp data %0d", u, i), data_o[u], p);
      end
      rd[u] = 1'b1;
      @(negedge clk);
      rd[u] = 1'b0;
      check_idle(u);
      check($sformatf("u%0d data after accept", u), data_o[u], p);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         st[i] = 1'b0;
         rd[i] = 1'b0;
         pat[i] = 8'h00;
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check_idle(i);
         check($sformatf("u%0d reset data", i), data_o[i], 8'h00);
      end
      rst = 1'b0;
      @(negedge clk);
      scan(0, 1, 8'hA6, 1'b1, 0);
      accept(0, 5, 8'hA6);
      scan(2, 0, 8'h5A, 1'b1, 0);
      accept(2, 0, 8'h5A);
      scan(0, 1, 8'h3C, 1'b1, 5);
      st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      check("u0 hold start valid", 8'(vld_o[0]), 8'd1);
      check("u0 hold start sel", 8'(sel_o[0]), 8'd0);
      accept(0, 0, 8'h3C);
      repeat (2) @(negedge clk);
      check("u0 no queued scan", 8'(busy_o[0]), 8'd0);
      rd[1] = 1'b1;
      scan(1, 1, 8'hFF, 1'b1, 0);
      pat[1] = 8'h01;
      @(negedge clk);
      check("u1 accept valid", 8'(vld_o[1]), 8'd0);
      check("u1 accept busy", 8'(busy_o[1]), 8'd1);
      check("u1 accept sel", 8'(sel_o[1]), 8'd0);
      rd[1] = 1'b1;
      scan(1, 1, 8'h01, 1'b0, 0);
      rd[1] = 1'b0;
      @(negedge clk);
      check("u1 held valid", 8'(vld_o[1]), 8'd1);
      check("u1 held data", data_o[1], 8'h01);
      pat[0] = 8'hFF;
      st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      repeat (8) @(negedge clk);
      check("u0 pre-rst sel", 8'(sel_o[0]), 8'd4);
      rst = 1'b1;
      st[0] = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      st[0] = 1'b0;
      check_idle(0);
      check("u0 rst data", data_o[0], 8'h00);
      check_idle(1);
      scan(0, 1, 8'hC3, 1'b1, 0);
      accept(0, 0, 8'hC3);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
